// File: rtl/telem_pkg.sv
// Shared constants, defaults and reader FSM state encoding for the telemetry readout path.
// TELEM_READER_CHECKSUM_EN adds the trailing checksum state.
package telem_pkg;

  localparam logic [7:0] TELEM_HDR              = 8'hA5;
  localparam int         TELEM_BYTES_PER_TARGET = 5;
  localparam int         TELEM_NUM_TARGETS      = 16;
  localparam int         TELEM_COORD_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_LATCH = 3'd3,
`ifdef TELEM_READER_CHECKSUM_EN
    ST_SEND  = 3'd4,
    ST_CHK   = 3'd5
`else
    ST_SEND  = 3'd4
`endif
  } telem_state_e;

endpackage

// File: rtl/telem_target_reader_if.sv
// Target-store read port plus byte stream handshake used by telem_target_reader.
interface telem_target_reader_if #(parameter int COORD_W = 8);

  logic               rd_en;
  logic [3:0]         rd_sel;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [COORD_W-1:0] rd_z;
  logic [COORD_W-1:0] rd_t;
  logic [COORD_W-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               tx_last;

  modport master (
    output rd_en, rd_sel, tx_data, tx_valid, tx_last,
    input  rd_x, rd_y, rd_z, rd_t, tx_ready
  );

  modport slave (
    input  rd_en, rd_sel, tx_data, tx_valid, tx_last,
    output rd_x, rd_y, rd_z, rd_t, tx_ready
  );

endinterface

// File: rtl/telem_xor_acc.sv
// Running XOR of transferred frame bytes; used only when TELEM_READER_CHECKSUM_EN is defined.
module telem_xor_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/telem_target_reader.sv
// Sweeps all target slots and streams header + per-slot {idx,X,Y,Z,T} bytes.
// Optional trailing XOR checksum byte under TELEM_READER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// HDR   | presenting header byte
// FETCH | read strobe to store for slot idx
// LATCH | capture store read data into holding registers
// SEND  | presenting byte cnt of slot idx
// CHK   | presenting checksum byte (checksum build only)
module telem_target_reader
  import telem_pkg::*;
#(
  parameter int NUM_TARGETS = TELEM_NUM_TARGETS,
  parameter int COORD_W     = TELEM_COORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  telem_target_reader_if.master  bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_TARGETS - 1);
  localparam logic [2:0] LAST_CNT = 3'(TELEM_BYTES_PER_TARGET - 1);

  telem_state_e        state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          rd_sel_q, rd_sel_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d, t_q, t_d;
  logic                done_q, done_d;

  logic                rd_en;
  logic                tx_valid;
  logic                tx_last;
  logic [COORD_W-1:0]  tx_data;

`ifdef TELEM_READER_CHECKSUM_EN
  logic [COORD_W-1:0]  chk_acc;

  telem_xor_acc #(.W(COORD_W)) u_xor_acc (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_HDR),
    .en  ((state_q == ST_SEND) && bus.tx_ready),
    .din (tx_data),
    .acc (chk_acc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rd_sel_d = rd_sel_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    t_d      = t_q;
    done_d   = 1'b0;
    rd_en    = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          idx_d   = '0;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = COORD_W'(TELEM_HDR);
        if (bus.tx_ready) begin
          state_d  = ST_FETCH;
          rd_sel_d = idx_q;
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        x_d     = bus.rd_x;
        y_d     = bus.rd_y;
        z_d     = bus.rd_z;
        t_d     = bus.rd_t;
        cnt_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        case (cnt_q)
          3'd0:    tx_data = COORD_W'(idx_q);
          3'd1:    tx_data = x_q;
          3'd2:    tx_data = y_q;
          3'd3:    tx_data = z_q;
          default: tx_data = t_q;
        endcase
`ifndef TELEM_READER_CHECKSUM_EN
        tx_last = (cnt_q == LAST_CNT) && (idx_q == LAST_IDX);
`endif
        if (bus.tx_ready) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 3'd1;
          end else if (idx_q != LAST_IDX) begin
            idx_d    = idx_q + 4'd1;
            rd_sel_d = idx_q + 4'd1;
            state_d  = ST_FETCH;
          end else begin
`ifdef TELEM_READER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef TELEM_READER_CHECKSUM_EN
      ST_CHK: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = chk_acc;
        if (bus.tx_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      rd_sel_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      t_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rd_sel_q <= rd_sel_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      t_q      <= t_d;
      done_q   <= done_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign bus.rd_en    = rd_en;
  assign bus.rd_sel   = rd_sel_q;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_last  = tx_last;
  assign bus.tx_data  = tx_data;

endmodule

// File: tb/tb_telem_target_reader.sv
// Randomized self-checking bench for telem_target_reader against a frame-level reference model.
module tb_telem_target_reader;

  localparam int NT = 16;
  localparam int CW = 8;
`ifdef TELEM_READER_CHECKSUM_EN
  localparam int FRAME_LEN = 1 + NT * 5 + 1;
  localparam int FRAME_CYC = 1 + NT * 7 + 1;
`else
  localparam int FRAME_LEN = 1 + NT * 5;
  localparam int FRAME_CYC = 1 + NT * 7;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  telem_target_reader_if #(.COORD_W(CW)) bus();

  telem_target_reader #(.NUM_TARGETS(NT), .COORD_W(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // target store: registered read port
  logic [7:0] mx[NT], my[NT], mz[NT], mt[NT];
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_x <= mx[bus.rd_sel];
      bus.rd_y <= my[bus.rd_sel];
      bus.rd_z <= mz[bus.rd_sel];
      bus.rd_t <= mt[bus.rd_sel];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 0;

  logic [7:0] cap_data[$];
  bit         cap_last[$];
  int         last_xfer_cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         stall_viol = 0;
  bit         have_prev = 0;
  logic       pv, pr, pl;
  logic [7:0] pd;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      have_prev = 0;
    end else begin
      if (have_prev && pv && !pr)
        if (!(bus.tx_valid && bus.tx_data == pd && bus.tx_last == pl)) stall_viol++;
      if (bus.tx_valid && bus.tx_ready) begin
        cap_data.push_back(bus.tx_data);
        cap_last.push_back(bus.tx_last);
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pv = bus.tx_valid; pr = bus.tx_ready; pd = bus.tx_data; pl = bus.tx_last;
      have_prev = 1;
    end
  end

  // reference model: expected frame from snapshot arrays
  logic [7:0] ex[NT], ey[NT], ez[NT], et[NT];
  logic [7:0] exp_q[$];

  task automatic snapshot();
    for (int i = 0; i < NT; i++) begin
      ex[i] = mx[i]; ey[i] = my[i]; ez[i] = mz[i]; et[i] = mt[i];
    end
  endtask

  task automatic build_exp();
    logic [7:0] sum;
    sum = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NT; i++) begin
      exp_q.push_back(8'(i)); exp_q.push_back(ex[i]); exp_q.push_back(ey[i]);
      exp_q.push_back(ez[i]); exp_q.push_back(et[i]);
      sum = sum ^ 8'(i) ^ ex[i] ^ ey[i] ^ ez[i] ^ et[i];
    end
`ifdef TELEM_READER_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic pulse_start(output int s_cyc);
    s_cyc = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL wait_done timeout after %0d cycles, done never seen", budget);
    end
  endtask

  task automatic wait_bytes(input int nbytes, input int budget);
    int n;
    n = 0;
    while (cap_data.size() < nbytes && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (cap_data.size() < nbytes) begin
      errors++;
      $display("FAIL wait_bytes got %0d bytes need %0d", cap_data.size(), nbytes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 7;
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (bus.rd_en !== 1'b0)    begin errors++; $display("FAIL rst_rd_en got %b exp 0", bus.rd_en); end
    if (bus.rd_sel !== 4'h0)   begin errors++; $display("FAIL rst_rd_sel got %h exp 0", bus.rd_sel); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", bus.tx_data); end
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", bus.tx_valid); end
    if (bus.tx_last !== 1'b0)  begin errors++; $display("FAIL rst_tx_last got %b exp 0", bus.tx_last); end
    if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int s_cyc;
    int nl;
    for (int i = 0; i < NT; i++) begin
      mx[i] = 8'(i); my[i] = 8'(8'h10 + i); mz[i] = 8'(8'h20 + i); mt[i] = 8'(8'h30 + i);
    end
    snapshot();
    build_exp();
    rand_ready = 0;
    cap_data.delete(); cap_last.delete();
    pulse_start(s_cyc);
    wait_done(400);
    checks++;
    if (cap_data.size() != FRAME_LEN) begin
      errors++; $display("FAIL basic_len got %0d exp %0d", cap_data.size(), FRAME_LEN);
    end
    for (int i = 0; i < cap_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_byte[%0d] got %h exp %h", i, cap_data[i], exp_q[i]);
      end
    end
    nl = 0;
    foreach (cap_last[i]) if (cap_last[i]) nl++;
    checks++;
    if (nl != 1 || cap_last.size() == 0 || !cap_last[cap_last.size()-1]) begin
      errors++; $display("FAIL basic_last count %0d on_final %0d exp 1", nl,
                         cap_last.size() > 0 ? int'(cap_last[cap_last.size()-1]) : 0);
    end
    checks++;
    if (done_cyc != last_xfer_cyc + 1) begin
      errors++; $display("FAIL basic_done_timing got cyc %0d exp %0d", done_cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (last_xfer_cyc - s_cyc != FRAME_CYC) begin
      errors++; $display("FAIL basic_frame_cycles got %0d exp %0d", last_xfer_cyc - s_cyc, FRAME_CYC);
    end
  endtask

  task automatic test_stall();
    int s_cyc;
    for (int i = 0; i < NT; i++) begin
      mx[i] = 8'($urandom); my[i] = 8'($urandom); mz[i] = 8'($urandom); mt[i] = 8'($urandom);
    end
    snapshot();
    build_exp();
    stall_viol = 0;
    rand_ready = 1;
    cap_data.delete(); cap_last.delete();
    pulse_start(s_cyc);
    wait_done(2000);
    rand_ready = 0;
    checks++;
    if (cap_data.size() != FRAME_LEN) begin
      errors++; $display("FAIL stall_len got %0d exp %0d", cap_data.size(), FRAME_LEN);
    end
    for (int i = 0; i < cap_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_byte[%0d] got %h exp %h", i, cap_data[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL stall_stability got %0d violations exp 0", stall_viol);
    end
  endtask

  task automatic test_start_ignored();
    int s_cyc;
    int d0;
    int busy_seen;
    int n0;
    int n;
    snapshot();
    build_exp();
    rand_ready = 0;
    cap_data.delete(); cap_last.delete();
    d0 = done_cnt;
    pulse_start(s_cyc);
    wait_bytes(20, 200);
    pulse_start(s_cyc);
    wait_done(400);
    checks++;
    if (cap_data.size() != FRAME_LEN) begin
      errors++; $display("FAIL restart_len got %0d exp %0d", cap_data.size(), FRAME_LEN);
    end
    for (int i = 0; i < cap_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL restart_byte[%0d] got %h exp %h", i, cap_data[i], exp_q[i]);
      end
    end
    busy_seen = 0;
    n0 = cap_data.size();
    repeat (150) begin
      step();
      if (busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || cap_data.size() != n0 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL no_queued_start busy %0d bytes %0d dones %0d exp 0 %0d %0d",
                         busy_seen, cap_data.size(), done_cnt - d0, n0, 1);
    end
    // start on the done cycle
    pulse_start(s_cyc);
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL done_cycle_wait got done 0 exp 1");
    end
    cap_data.delete(); cap_last.delete();
    pulse_start(s_cyc);
    wait_done(400);
    checks++;
    if (cap_data.size() != FRAME_LEN || cap_data[0] !== 8'hA5) begin
      errors++; $display("FAIL start_on_done len %0d first %h exp %0d a5", cap_data.size(),
                         cap_data.size() > 0 ? cap_data[0] : 8'h00, FRAME_LEN);
    end
  endtask

  task automatic test_reset_mid();
    int s_cyc;
    snapshot();
    build_exp();
    rand_ready = 0;
    cap_data.delete(); cap_last.delete();
    pulse_start(s_cyc);
    wait_bytes(40, 200);
    rst = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid got %b exp 0", bus.tx_valid); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data got %h exp 00", bus.tx_data); end
    if (bus.rd_sel !== 4'h0 || bus.rd_en !== 1'b0 || bus.tx_last !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_misc got sel %h en %b last %b done %b exp 0", bus.rd_sel,
                         bus.rd_en, bus.tx_last, done);
    end
    repeat (2) step();
    rst = 1'b1;
    step();
    cap_data.delete(); cap_last.delete();
    pulse_start(s_cyc);
    wait_done(400);
    checks++;
    if (cap_data.size() != FRAME_LEN) begin
      errors++; $display("FAIL postrst_len got %0d exp %0d", cap_data.size(), FRAME_LEN);
    end
    for (int i = 0; i < cap_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL postrst_byte[%0d] got %h exp %h", i, cap_data[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rewrite();
    int s_cyc;
    snapshot();
    ex[10] = 8'hC3; ey[10] = 8'h5A; ez[10] = 8'h96; et[10] = 8'h69;
    build_exp();
    rand_ready = 0;
    cap_data.delete(); cap_last.delete();
    pulse_start(s_cyc);
    // slot 3 idx byte just transferred: slot 3 is latched, X..T still pending
    wait_bytes(1 + 3 * 5 + 1, 200);
    mx[3] = 8'hFF; my[3] = 8'hFF; mz[3] = 8'hFF; mt[3] = 8'hFF;
    mx[10] = 8'hC3; my[10] = 8'h5A; mz[10] = 8'h96; mt[10] = 8'h69;
    wait_done(400);
    checks++;
    if (cap_data.size() != FRAME_LEN) begin
      errors++; $display("FAIL rewrite_len got %0d exp %0d", cap_data.size(), FRAME_LEN);
    end
    for (int i = 0; i < cap_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL rewrite_byte[%0d] got %h exp %h", i, cap_data[i], exp_q[i]);
      end
    end
  endtask

`ifdef TELEM_READER_CHECKSUM_EN
  task automatic test_checksum_zero();
    int s_cyc;
    for (int i = 0; i < NT; i++) begin
      mx[i] = 8'h00; my[i] = 8'h00; mz[i] = 8'h00; mt[i] = 8'h00;
    end
    rand_ready = 1;
    cap_data.delete(); cap_last.delete();
    pulse_start(s_cyc);
    wait_done(2000);
    rand_ready = 0;
    checks++;
    if (cap_data.size() != 82 || cap_data[81] !== 8'h00 || !cap_last[81]) begin
      errors++; $display("FAIL checksum_zero len %0d byte %h last %0d exp 82 00 1", cap_data.size(),
                         cap_data.size() > 81 ? cap_data[81] : 8'hEE,
                         cap_data.size() > 81 ? int'(cap_last[81]) : 0);
    end
  endtask
`endif

  initial begin
    bus.tx_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_rewrite();
`ifdef TELEM_READER_CHECKSUM_EN
    test_checksum_zero();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
